tri_csa_resolve: RTL and testbench
==================================

# tri_csa_resolve

Multi-cycle carry-propagate resolver that turns a redundant carry-save pair (sum vector, carry vector) back into a single binary result. It sits downstream of carry-save compression trees, such as multiplier partial-product reduction and multi-operand accumulation, and performs the final carry-propagate add. It adds CHUNK bits per cycle through a registered chunk carry to keep the ripple path short. A valid/ready handshake is used on both sides.

## Interface
- WIDTH, 64: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 16: bits resolved per cycle; N = WIDTH/CHUNK chunk cycles per operation.
- clk  in  1  clock; one clock domain, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept; equals (state==IDLE) & ~rst.
- in_sum  in  WIDTH  sum vector of the carry-save pair.
- in_car  in  WIDTH  carry vector, already aligned (value = in_sum + in_car).
- in_cin  in  1  carry-in added at bit 0.
- out_valid  out  1  result available; equals (state==DONE).
- out_ready  in  1  consumer takes result.
- out_res  out  WIDTH  binary result, (in_sum + in_car + in_cin) mod 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.
- out_ovf  out  1  signed overflow; present only with TRI_CSA_RESOLVE_OVF_EN.

## Operation
- States: IDLE, RUN, DONE. Chunk index idx is a ceil(log2 N)-bit counter. Registered chunk carry is cy.
- IDLE: when in_valid is high on an edge, the block does the following:
  - captures in_sum and in_car;
  - sets cy = in_cin and idx = 0;
  - clears out_res, out_cout and out_ovf;
  - goes to RUN.
- RUN, on each edge:
  - {c, r} = in_sum[idx chunk] + in_car[idx chunk] + cy, a (CHUNK+1)-bit add;
  - out_res[idx chunk] takes r, cy takes c, idx increments;
  - on the edge where idx == N-1, out_cout takes c and the state goes to DONE.
- DONE: out_res and out_cout are held stable while out_ready is low. An edge with out_ready high returns the state to IDLE.
- in_valid is ignored outside IDLE. The producer must hold the operands only until the acceptance edge.
- The accept edge and the handoff edge are separate edges. There is no same-cycle handoff-and-accept.
- N == 1 is legal: RUN lasts exactly one edge.
- Arithmetic is unsigned modulo 2^WIDTH. Bits above WIDTH are not retained beyond out_cout.

## Timing
- Reset (rst high on an edge):
  - state becomes IDLE, idx 0 and cy 0;
  - out_res 0, out_cout 0, out_ovf 0;
  - out_valid is 0, and in_ready is 0 while rst is high.
- Reset mid-operation (RUN or DONE) aborts: the partial result is discarded and out_valid drops on the next edge. in_ready returns to 1 on the first cycle with rst low.
- Latency: out_valid goes high N edges after the accept edge (4 for the defaults).
- Minimum initiation interval is N+2 cycles: accept, N RUN edges, then the handoff edge.
- in_ready and out_valid are pure state decodes with no combinational path from in_valid or out_ready.
- out_res and out_cout change only during RUN and at reset. They are stable for the whole of DONE.

## Configuration
- TRI_CSA_RESOLVE_OVF_EN defined:
  - adds port out_ovf;
  - on the final RUN edge it registers cin_msb ^ c, where cin_msb is the carry into bit WIDTH-1 and c is the carry out;
  - out_ovf is valid in DONE and is cleared on reset and on accept.
- Not defined: the out_ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=64, CHUNK=16. Full carry ripple:
  - stimulus: in_sum=0xFFFF_FFFF_FFFF_FFFF, in_car=0x1, in_cin=0;
  - response: out_res=0, out_cout=1, out_valid exactly 4 edges after accept.
- Chunk boundary carry:
  - stimulus: in_sum=0x0000_0000_0000_FFFF, in_car=0x0, in_cin=1;
  - response: out_res=0x0000_0000_0001_0000, out_cout=0.
- Backpressure:
  - stimulus: out_ready held 0 for 10 cycles in DONE;
  - response: out_valid=1, out_res stable and in_ready=0 throughout;
  - then out_ready=1 for 1 cycle gives IDLE on the next edge, and a new accept no earlier than the following edge.
- Reset mid-run:
  - stimulus: rst asserted on the second RUN edge;
  - response: out_valid never rises, out_res=0; in_ready=1 the cycle after rst falls; the next operation resolves correctly.
- Overflow (macro defined):
  - stimulus: in_sum=0x7FFF_FFFF_FFFF_FFFF, in_car=0x1, in_cin=0;
  - response: out_res=0x8000_0000_0000_0000, out_ovf=1, out_cout=0;
  - with the macro undefined, the build has no out_ovf port.
- Random:
  - stimulus: 1000 random (in_sum, in_car, in_cin), in_valid held high, random out_ready;
  - response: every {out_cout, out_res} equals in_sum+in_car+in_cin; no result is dropped or duplicated; initiation interval ≥ 6.

Source files
------------

// File: rtl/tri_csa_resolve_if.sv
`default_nettype none
// ============================================================================
// Module  : tri_csa_resolve_if
// Brief   : Operand/result handshake bundle for tri_csa_resolve.
//           out_ovf exists only when TRI_CSA_RESOLVE_OVF_EN is defined.
// Revision: 1.0
// ============================================================================
interface tri_csa_resolve_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_car;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_cout;
`ifdef TRI_CSA_RESOLVE_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_sum, in_car, in_cin, out_ready,
`ifdef TRI_CSA_RESOLVE_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_res, out_cout
  );

  modport slave (
    input  in_valid, in_sum, in_car, in_cin, out_ready,
`ifdef TRI_CSA_RESOLVE_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_res, out_cout
  );
endinterface
`default_nettype wire

// File: rtl/tri_csa_resolve.sv
`default_nettype none
// ============================================================================
// Module  : tri_csa_resolve
// Brief   : Multi-cycle carry-propagate resolver for a carry-save pair,
//           CHUNK bits per cycle. Optional macro: TRI_CSA_RESOLVE_OVF_EN.
// Revision: 1.0
// ============================================================================
module tri_csa_resolve #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  tri_csa_resolve_if.slave bus
);
  localparam int c_N  = WIDTH / CHUNK;
  localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_car;
  logic [WIDTH-1:0] r_res;
  logic [c_IW-1:0]  r_idx;
  logic             r_cy;
  logic             r_cout;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK:0]   w_add;
  logic             w_last;
`ifdef TRI_CSA_RESOLVE_OVF_EN
  logic             r_ovf;
  logic             w_cin_msb;
`endif

  assign w_last = (r_idx == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Chunk select by decoded index keeps the mux free of variable shifts.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < c_N; k++) begin
      if (r_idx == c_IW'(k)) begin
        w_a = r_sum[k*CHUNK +: CHUNK];
        w_b = r_car[k*CHUNK +: CHUNK];
      end
    end
  end

  assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, r_cy};
`ifdef TRI_CSA_RESOLVE_OVF_EN
  assign w_cin_msb = w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_add[CHUNK-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_car  <= '0;
      r_res  <= '0;
      r_idx  <= '0;
      r_cy   <= 1'b0;
      r_cout <= 1'b0;
`ifdef TRI_CSA_RESOLVE_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_sum  <= bus.in_sum;
            r_car  <= bus.in_car;
            r_cy   <= bus.in_cin;
            r_idx  <= '0;
            r_res  <= '0;
            r_cout <= 1'b0;
`ifdef TRI_CSA_RESOLVE_OVF_EN
            r_ovf  <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          for (int k = 0; k < c_N; k++) begin
            if (r_idx == c_IW'(k)) begin
              r_res[k*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
            end
          end
          r_cy  <= w_add[CHUNK];
          r_idx <= r_idx + c_IW'(1);
          if (w_last) begin
            r_cout <= w_add[CHUNK];
`ifdef TRI_CSA_RESOLVE_OVF_EN
            r_ovf  <= w_cin_msb ^ w_add[CHUNK];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE) & ~rst;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_res   = r_res;
  assign bus.out_cout  = r_cout;
`ifdef TRI_CSA_RESOLVE_OVF_EN
  assign bus.out_ovf   = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tri_csa_resolve.sv
`default_nettype none
// ============================================================================
// Module  : tb_tri_csa_resolve
// Brief   : Scoreboard bench for tri_csa_resolve (WIDTH=64, CHUNK=16).
// Revision: 1.0
// ============================================================================
module tb_tri_csa_resolve;
  typedef struct packed {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  logic man_rdy;
  logic rnd_rdy;
  logic rand_mode;
  int   n_chk;
  int   n_fail;
  int   n_push;
  int   n_pop;
  int   cyc;
  int   acc_cyc;
  exp_t exp_q[$];

  tri_csa_resolve_if #(.WIDTH(64)) bus ();

  tri_csa_resolve #(.WIDTH(64), .CHUNK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.out_ready = rand_mode ? rnd_rdy : man_rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2 rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] s, input logic [63:0] c, input logic ci);
    logic [64:0]        t;
    logic signed [65:0] st;
    exp_t               e;
    t  = {1'b0, s} + {1'b0, c} + {64'b0, ci};
    st = $signed({{2{s[63]}}, s}) + $signed({{2{c[63]}}, c}) + $signed({65'b0, ci});
    e.res  = t[63:0];
    e.cout = t[64];
    e.ovf  = !((st[65:63] == 3'b000) || (st[65:63] == 3'b111));
    return e;
  endfunction

  // Offer an operand pair; the expected result is queued at acceptance.
  task automatic send(input logic [63:0] s, input logic [63:0] c, input logic ci,
                      input logic [63:0] er, input logic ec, input logic eo, input bit hold);
    bit   got;
    exp_t e;
    bus.in_sum   = s;
    bus.in_car   = c;
    bus.in_cin   = ci;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 65'd0, 65'd1);
      bus.in_valid = 1'b0;
      return;
    end
    e.res = er; e.cout = ec; e.ovf = eo;
    exp_q.push_back(e);
    n_push++;
    @(posedge clk);
    #2;
    acc_cyc = cyc;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) chk("valid_timeout", 65'd0, 65'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 65'd0, 65'd1);
  endtask

  // Monitor: a handoff edge follows every sample with out_valid and out_ready high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {bus.out_cout, bus.out_res}, 65'd0);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          chk("res", {1'b0, bus.out_res}, {1'b0, e.res});
          chk("cout", {64'b0, bus.out_cout}, {64'b0, e.cout});
`ifdef TRI_CSA_RESOLVE_OVF_EN
          chk("ovf", {64'b0, bus.out_ovf}, {64'b0, e.ovf});
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        m;
    int          lat;
    int          prev;
    logic [63:0] rs, rc;
    logic        rci;
    n_chk = 0; n_fail = 0; n_push = 0; n_pop = 0; acc_cyc = 0;
    rst = 1'b1; man_rdy = 1'b1; rand_mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_car = '0; bus.in_cin = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {64'b0, bus.in_ready}, 65'd0);
    chk("rst_out_valid", {64'b0, bus.out_valid}, 65'd0);
    chk("rst_out_res", {1'b0, bus.out_res}, 65'd0);
    chk("rst_out_cout", {64'b0, bus.out_cout}, 65'd0);
`ifdef TRI_CSA_RESOLVE_OVF_EN
    chk("rst_out_ovf", {64'b0, bus.out_ovf}, 65'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {64'b0, bus.in_ready}, 65'd1);

    // Full ripple through all chunks, with latency measurement.
    @(posedge clk); #2;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("latency", 65'(lat), 65'd4);
    wait_drain();

    // Chunk-boundary carry held under backpressure.
    man_rdy = 1'b0;
    send(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {64'b0, bus.out_valid}, 65'd1);
      chk("bp_res", {1'b0, bus.out_res}, 65'h0000_0000_0001_0000);
      chk("bp_in_ready", {64'b0, bus.in_ready}, 65'd0);
    end
    @(posedge clk);
    #2 man_rdy = 1'b1;
    @(negedge clk);
    chk("handoff_in_ready", {64'b0, bus.in_ready}, 65'd0);
    @(posedge clk);
    #2 man_rdy = 1'b0;
    @(negedge clk);
    chk("post_handoff_in_ready", {64'b0, bus.in_ready}, 65'd1);
    chk("post_handoff_valid", {64'b0, bus.out_valid}, 65'd0);
    @(posedge clk);
    #2 man_rdy = 1'b1;

    // Reset on the second RUN edge aborts the operation.
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
         64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_hi_in_ready", {64'b0, bus.in_ready}, 65'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    void'(exp_q.pop_back());
    n_push--;
    @(negedge clk);
    chk("abort_in_ready", {64'b0, bus.in_ready}, 65'd1);
    chk("abort_res", {1'b0, bus.out_res}, 65'd0);
    chk("abort_cout", {64'b0, bus.out_cout}, 65'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_valid", {64'b0, bus.out_valid}, 65'd0);
    end
    @(posedge clk); #2;
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
         64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1, 1'b1, 1'b0);
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Random traffic with in_valid held and random consumer readiness.
    rand_mode = 1'b1;
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      rs  = {$urandom(), $urandom()};
      rc  = {$urandom(), $urandom()};
      rci = 1'($urandom_range(0, 1));
      m   = model(rs, rc, rci);
      send(rs, rc, rci, m.res, m.cout, m.ovf, 1'b1);
      if (i > 0) chk("init_interval_ge6", 65'(acc_cyc - prev >= 6), 65'd1);
      prev = acc_cyc;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rand_mode = 1'b0;
    wait_drain();
    chk("queue_empty", 65'(exp_q.size()), 65'd0);
    chk("push_pop_count", 65'(n_pop), 65'(n_push));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
